rr_burst_mux: RTL and testbench
===============================

Name: rr_burst_mux

Overview:
- Round-robin burst scheduler. Shares one downstream streaming channel between N requesters.
- A winner is chosen by rotating priority. The winner then owns the channel for a whole burst of req_len+1 beats; no other requester can interleave.
- Sits between N producer streams (DMA engines, packet sources) and a single shared sink.
- Adds arbitration plus valid/ready handshaking and beat counting on top of plain grant-per-cycle arbitration.

Parameters:
- N, 4, number of requesters (1..16).
- DW, 8, data width per beat.
- LW, 4, burst length field width. Burst length = req_len+1, i.e. 1..2^LW beats.
- SW, derived = max(1, clog2(N)), width of the source index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N  per-requester beat valid; bit i belongs to requester i.
- req_len  in  N*LW  per-requester burst length minus one; slice i is [i*LW +: LW].
- req_data  in  N*DW  per-requester beat data; slice i is [i*DW +: DW].
- req_ready  out  N  per-requester beat accepted; one-hot or zero.
- out_valid  out  1  downstream beat valid.
- out_data  out  DW  downstream beat data.
- out_src  out  SW  index of the current burst owner.
- out_last  out  1  marks the final beat of a burst.
- out_ready  in  1  downstream ready.
- busy  out  1  high while a burst is owned (state BURST).

Behaviour:
- FSM states: IDLE and BURST. Reset state is IDLE.
- Registers:
  - owner (SW bits).
  - cnt (LW bits), beats remaining minus one.
  - ptr (SW bits), highest-priority index.
- Reset values: owner=0, cnt=0, ptr=0.
- Outputs during reset and in IDLE: req_ready=0, out_valid=0, out_last=0, busy=0, out_data=0, out_src=owner.

IDLE:
- If any req_valid bit is set, the winner is the first set bit scanning ptr, ptr+1, … N-1, 0, … ptr-1 (wrap-around).
- At that clock edge: owner<=winner, cnt<=req_len[winner], state<=BURST.
- No beat is transferred in IDLE. Arbitration costs exactly 1 cycle per burst.
- If no req_valid bit is set, stay in IDLE; all registers hold.

BURST:
- out_valid = req_valid[owner]. out_data = req_data[owner]. out_src = owner. These are combinational from the owner's inputs.
- req_ready[owner] = out_ready. All other req_ready bits are 0.
- out_last = (cnt==0) & out_valid.
- A beat transfers when out_valid & out_ready.
- On a non-last transfer: cnt<=cnt-1.
- On the last transfer (cnt==0): state<=IDLE, ptr<=(owner==N-1) ? 0 : owner+1.
- Owner deasserting req_valid mid-burst creates bubbles. The burst stays owned and cnt holds. There is no timeout.
- out_ready low stalls: cnt holds and out_data follows the owner's held data.
- req_len is sampled only at grant. Changes to req_len during a burst are ignored.
- Other requesters' req_valid is ignored during BURST. They are considered at the next IDLE cycle.

Fairness:
- Once a burst completes, the just-served requester gets the lowest priority.
- With all N requesting continuously, grants cycle 0,1,…,N-1,0,…

Boundary conditions:
- Single-beat burst (req_len=0): BURST lasts until the one transfer completes; out_last is high on that beat.
- Maximum length (req_len=2^LW-1): exactly 2^LW transfers, no counter wrap.
- N=1: ptr is always 0. Behaviour is otherwise identical.
- Reset mid-burst: on the next edge, return to IDLE with ptr=0. The partially transferred burst is abandoned; the sink sees no out_last.
- Simultaneous last transfer and new requests: no grant in the same cycle. The new grant happens in the following IDLE cycle, using the updated ptr.

Throughput:
- Burst of L beats with no stalls takes L+1 cycles, including the arbitration cycle.

Test Plan:
- Single requester: rst, then req_valid=4'b0100, req_len[2]=3, out_ready=1, data 0xA0..0xA3.
  -> Grant cycle, then 4 beats with out_src=2 and out_data A0,A1,A2,A3; out_last on A3; busy for 4 cycles; ptr becomes 3.
- All four requesting, len=0 each, out_ready=1.
  -> out_src sequence 0,1,2,3,0; one beat every 2 cycles; each beat carries out_last.
- Backpressure: requester 1, len=2; toggle out_ready 1,0,0,1,1.
  -> Exactly 3 transfers; req_ready[1] mirrors out_ready; cnt holds on stall; out_last on the third accepted beat only.
- Mid-burst bubble and lockout: requester 0 has len=3 and drops req_valid for 2 cycles after beat 1; requester 3 is valid throughout.
  -> out_valid low for 2 cycles; requester 3 is not granted until requester 0's 4th beat completes, then out_src=3.
- Wrap priority: ptr=3 (after a grant to 2), then req_valid=4'b1001.
  -> Requester 3 wins; next grant goes to 0.
- Reset mid-burst: rst pulsed during beat 2 of a len=5 burst.
  -> Next cycle busy=0, out_valid=0, req_ready=0. After release, req_valid=4'b0011 grants requester 0 (ptr=0).

Source files
------------

// File: rtl/rr_burst_mux.sv
// Round-robin burst mux: N requesters share one stream; a winner owns it for req_len+1 beats.
// One arbitration cycle per burst, then owner beats pass through combinationally; out_ready low stalls the owner via req_ready.
module rr_burst_mux #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int LW = 4,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*LW-1:0] req_len,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [SW-1:0]   out_src,
    output logic            out_last,
    input  logic            out_ready,
    output logic            busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          found;
    logic [SW-1:0] winner;
    logic          own_valid;
    logic          xfer;

    // Rotating-priority scan starting at ptr, wrapping past N-1 back to 0.
    always_comb begin : p_arb
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = SW'(idx);
            end
        end
    end

    assign own_valid = req_valid[owner_q];
    assign xfer      = (state_q == BURST) && own_valid && out_ready;

    // Outputs are forced idle while rst is held so a reset mid-burst is seen immediately.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_src   = owner_q;
        out_last  = 1'b0;
        busy      = 1'b0;
        if (state_q == BURST && !rst) begin
            busy               = 1'b1;
            out_valid          = own_valid;
            out_data           = req_data[int'(owner_q)*DW +: DW];
            req_ready[owner_q] = out_ready;
            out_last           = (cnt_q == '0) && own_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    cnt_d   = req_len[int'(winner)*LW +: LW];
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        ptr_d   = (owner_q == SW'(N-1)) ? '0 : owner_q + SW'(1);
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_burst_mux.sv
// Directed bench for rr_burst_mux: inputs change on the falling edge, outputs are checked 1ns later.
module tb_rr_burst_mux;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_last;
    logic            out_ready;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    logic rdy_pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic bp_last  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic bub_vld  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic bub_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    rr_burst_mux #(.N(N), .DW(DW), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
        req_len[i*LW +: LW]  = l;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_vld"},   32'(out_valid), 32'd0);
        check({tag, "_rdy"},   32'(req_ready), 32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    task automatic chk_beat(input string tag, input int src, input logic vld, input logic last,
                            input logic [DW-1:0] d, input logic [N-1:0] rdy);
        check({tag, "_busy"}, 32'(busy),      32'd1);
        check({tag, "_vld"},  32'(out_valid), 32'(vld));
        check({tag, "_src"},  32'(out_src),   32'(src));
        check({tag, "_last"}, 32'(out_last),  32'(last));
        check({tag, "_dat"},  32'(out_data),  32'(d));
        check({tag, "_rdy"},  32'(req_ready), 32'(rdy));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_len   = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk_idle("rst");
        check("rst_src", 32'(out_src), 32'd0);
        check("rst_dat", 32'(out_data), 32'd0);

        // Single requester 2, 4 beats A0..A3
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0100;
        set_req(2, 4'd3, 8'hA0);
        out_ready = 1'b1;
        #1 chk_idle("t1_grant");
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            req_data[2*DW +: DW] = 8'hA0 + 8'(b);
            #1 chk_beat($sformatf("t1_b%0d", b), 2, 1'b1, (b == 3), 8'hA0 + 8'(b), 4'b0100);
        end

        // Wrap priority: ptr=3, requesters 0 and 3 -> 3 first, then 0
        @(negedge clk);
        req_valid = 4'b1001;
        set_req(3, 4'd0, 8'h33);
        set_req(0, 4'd0, 8'h00);
        #1 chk_idle("wrap_idle0");
        @(negedge clk); #1 chk_beat("wrap_g3", 3, 1'b1, 1'b1, 8'h33, 4'b1000);
        @(negedge clk); #1 chk_idle("wrap_idle1");
        @(negedge clk); #1 chk_beat("wrap_g0", 0, 1'b1, 1'b1, 8'h00, 4'b0001);

        // All four requesting single beats, from ptr=0
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) set_req(i, 4'd0, 8'h40 + 8'(i));
        #1 chk_idle("rr_idle_first");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 chk_beat($sformatf("rr_k%0d", k), k % 4, 1'b1, 1'b1, 8'h40 + 8'(k % 4), 4'(1 << (k % 4)));
            if (k < 4) begin
                @(negedge clk);
                #1 chk_idle($sformatf("rr_gap%0d", k));
            end
        end

        // Backpressure on requester 1, len=2
        @(negedge clk);
        req_valid = 4'b0010;
        set_req(1, 4'd2, 8'h10);
        out_ready = 1'b1;
        #1 chk_idle("bp_grant");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = rdy_pat[c];
            req_data[1*DW +: DW] = 8'h10 + 8'(c);
            #1 chk_beat($sformatf("bp_c%0d", c), 1, 1'b1, bp_last[c], 8'h10 + 8'(c), {2'b00, rdy_pat[c], 1'b0});
        end
        @(negedge clk);
        req_valid = '0;
        out_ready = 1'b1;
        #1 chk_idle("bp_done");

        // Bubble and lockout: requester 0 len=3 drops valid for 2 cycles, requester 3 waits
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1001;
        set_req(0, 4'd3, 8'h50);
        set_req(3, 4'd0, 8'h77);
        #1 chk_idle("bub_grant");
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            req_valid[0] = bub_vld[j];
            req_data[0 +: DW] = 8'h50 + 8'(j);
            #1 chk_beat($sformatf("bub_j%0d", j), 0, bub_vld[j], bub_last[j], 8'h50 + 8'(j), 4'b0001);
        end
        @(negedge clk); #1 chk_idle("bub_idle");
        @(negedge clk); #1 chk_beat("bub_g3", 3, 1'b1, 1'b1, 8'h77, 4'b1000);

        // Move ptr to 1, then reset during beat 2 of a len=5 burst on requester 2
        @(negedge clk);
        req_valid = 4'b0001;
        set_req(0, 4'd0, 8'h60);
        #1 chk_idle("rm_pre");
        @(negedge clk); #1 chk_beat("rm_g0", 0, 1'b1, 1'b1, 8'h60, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0100;
        set_req(2, 4'd5, 8'h80);
        #1 chk_idle("rm_grant");
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            #1 chk_beat($sformatf("rm_b%0d", j), 2, 1'b1, 1'b0, 8'h80, 4'b0100);
        end
        @(negedge clk);
        rst = 1'b1;
        #1 chk_idle("rm_during");
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0011;
        set_req(0, 4'd0, 8'h90);
        set_req(1, 4'd0, 8'h91);
        #1 chk_idle("rm_after");
        check("rm_after_src", 32'(out_src), 32'd0);
        @(negedge clk); #1 chk_beat("rm_g", 0, 1'b1, 1'b1, 8'h90, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
